// File: rtl/rr_reg_arbiter.sv
// ============================================================================
// Module      : rr_reg_arbiter
// Description : Round-robin arbiter sequencing writes from N_REQ requesters
//               into one shared WIDTH-bit register. Optional grant locking
//               is enabled by defining RR_REG_ARBITER_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_reg_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int SRC_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_lock,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       q,
    output logic [SRC_W-1:0]       q_src,
    output logic                   q_upd,
    output logic                   busy
);

    localparam logic [SRC_W-1:0] c_LAST = SRC_W'(N_REQ - 1);

    logic [SRC_W-1:0] r_rr_ptr;
    logic [WIDTH-1:0] r_q;
    logic [SRC_W-1:0] r_q_src;
    logic             r_q_upd;

    logic             w_found;
    logic [SRC_W-1:0] w_gidx;
    logic [SRC_W-1:0] w_gidx_inc;
    logic [N_REQ-1:0] w_ready;
    logic             w_xfer;
    logic [SRC_W:0]   v_sum;
    logic [SRC_W-1:0] v_cand;

`ifdef RR_REG_ARBITER_LOCK_EN
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [0:0]       r_state;
    logic [SRC_W-1:0] r_owner;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock;
`endif

    // First valid index at or after r_rr_ptr, wrapping modulo N_REQ
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        v_sum   = '0;
        v_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (v_sum >= (SRC_W+1)'(N_REQ))
                v_sum = v_sum - (SRC_W+1)'(N_REQ);
            v_cand = v_sum[SRC_W-1:0];
            if (!w_found && req_valid[v_cand]) begin
                w_found = 1'b1;
                w_gidx  = v_cand;
            end
        end
`ifdef RR_REG_ARBITER_LOCK_EN
        if (r_state == c_LOCKED) begin
            w_found = req_valid[r_owner];
            w_gidx  = r_owner;
        end
`endif
    end

    always_comb begin
        w_ready = '0;
        if (en && !reset && w_found)
            w_ready[w_gidx] = 1'b1;
    end

    assign w_xfer     = en && !reset && w_found;
    assign w_gidx_inc = (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_q      <= '0;
            r_q_src  <= '0;
            r_q_upd  <= 1'b0;
        end else if (w_xfer) begin
            r_q     <= req_data[w_gidx*WIDTH +: WIDTH];
            r_q_src <= w_gidx;
            r_q_upd <= 1'b1;
`ifdef RR_REG_ARBITER_LOCK_EN
            // Pointer is frozen while locked; it moves on when the owner releases
            if (!req_lock[w_gidx])
                r_rr_ptr <= w_gidx_inc;
`else
            r_rr_ptr <= w_gidx_inc;
`endif
        end else begin
            r_q_upd <= 1'b0;
        end
    end

`ifdef RR_REG_ARBITER_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_owner <= '0;
        end else if (w_xfer) begin
            if (req_lock[w_gidx]) begin
                r_state <= c_LOCKED;
                r_owner <= w_gidx;
            end else begin
                r_state <= c_IDLE;
            end
        end
    end

    assign busy = (r_state == c_LOCKED);
`else
    assign busy = 1'b0;
`endif

    assign req_ready = w_ready;
    assign q         = r_q;
    assign q_src     = r_q_src;
    assign q_upd     = r_q_upd;

endmodule

`default_nettype wire

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit storage register (bank of D flip-flops) among N_REQ requesters.
- Each cycle, at most one requester's data is granted and captured into the register.
- Downstream logic reads q together with the source index and a one-cycle update strobe.
- Sits between the requesting blocks and the shared flip-flop storage, and sequences all writes to it.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, data width of each requester and of the shared register.
- SRC_W, $clog2(N_REQ), derived width of the source index. Not overridden by users.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- en  input  1  arbitration enable. When 0, no grants are issued and all state holds.
- req_valid  input  N_REQ  bit i set: requester i presents data.
- req_data  input  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- req_lock  input  N_REQ  bit i set: requester i asks to keep the grant. Used only with LOCK; ignored otherwise.
- req_ready  output  N_REQ  one-hot (or zero) grant, combinational in the same cycle.
- q  output  WIDTH  shared register contents.
- q_src  output  SRC_W  index of the requester that last wrote q.
- q_upd  output  1  one-cycle pulse: q was written on the previous edge.
- busy  output  1  1 while in LOCKED; always 0 without LOCK.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - reset is synchronous and active-high, sampled on the rising edge of clk, and overrides every other input.
- Reset values:
  - q=0, q_src=0, q_upd=0, busy=0.
  - Internal rr_ptr=0 (next priority index).
  - State=IDLE.
- Grant (state IDLE):
  - If en=1 and req_valid!=0, req_ready asserts the single bit for the first index with req_valid set, searching rr_ptr, rr_ptr+1, ... and wrapping modulo N_REQ.
  - If en=0 or req_valid=0, req_ready=0.
  - req_ready depends only on req_valid, en, rr_ptr and state. req_valid must not depend on req_ready.
- Transfer: occurs when req_valid[g] && req_ready[g]. At the next edge:
  - q <= req_data[g], q_src <= g, q_upd <= 1.
  - rr_ptr <= (g+1) mod N_REQ. Wrap: g=N_REQ-1 gives rr_ptr=0.
- No transfer in a cycle: q, q_src and rr_ptr hold; q_upd <= 0.
- Latency:
  - Grant is in the same cycle as the request.
  - q is visible 1 cycle after the transfer cycle.
  - q_upd is high for exactly that one cycle.
- Fairness: a requester holding req_valid continuously is granted within N_REQ transfers.
- en low: req_ready=0, no state change. rr_ptr, q and LOCKED ownership are all retained.
- Reset mid-operation: a transfer in the same cycle as reset is discarded; q=0 after the edge.
- States: IDLE always. LOCKED exists only with the optional feature.

Optional Feature:
- Macro: RR_REG_ARBITER_LOCK_EN.
- Defined: adds state LOCKED with a registered owner index.
  - IDLE -> LOCKED: a transfer from g with req_lock[g]=1. Owner <= g, busy <= 1, rr_ptr not advanced.
  - In LOCKED: req_ready = only the owner bit, gated by en and req_valid[owner]. Other requesters are never granted.
  - A transfer from the owner with req_lock=1 stays in LOCKED and writes q normally.
  - LOCKED -> IDLE: a transfer from the owner with req_lock[owner]=0. busy <= 0, rr_ptr <= (owner+1) mod N_REQ.
  - The owner dropping req_valid does not release the lock. There is no timeout. reset releases.
- Undefined: req_lock is ignored, busy is tied to 0, and there is no LOCKED state.

Test Plan:
- Reset: reset=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0 during reset; q=0, q_src=0, q_upd=0. After release, the first grant goes to index 0.
- Round robin: N_REQ=4, req_valid=4'b1111 held, data i = 8'hA0+i -> transfers in order 0,1,2,3,0. q follows A0,A1,A2,A3,A0 one cycle later; q_upd is high every cycle.
- Skip and wrap: rr_ptr=3, req_valid=4'b0010 -> req_ready=4'b0010. The next edge gives q_src=1 and rr_ptr=2. Then req_valid=4'b1001 -> grant goes to index 3, then index 0.
- en gating: req_valid=4'b0100, en=0 for 3 cycles -> req_ready=0, q holds, q_upd=0. en=1 -> grant to index 2 in the same cycle; q updates on the next edge.
- Reset mid-transfer: grant to index 1 with data 8'h5A while reset=1 -> after the edge q=0 and q_upd=0.
- LOCK (macro defined):
  - Index 2 transfers with req_lock=1 while req_valid=4'b1111 -> busy=1, and only index 2 is granted for 3 transfers.
  - Index 2 then transfers with req_lock=0 -> busy=0, and the next grant goes to index 3.
